cordic_trig_frontend: RTL

- Upstream stage that takes full-range angles and feeds the CORDIC sine stage.
- Accepts an angle in [-2pi, 2pi) and a sine/cosine select.
  - Cosine is converted to a sine via a +pi/2 offset.
  - The angle is wrapped to [-pi, pi], then folded into [-pi/2, pi/2].
  - The reduced angle is issued to the sine stage over its start/ready/done handshake.
- The returned value is registered and presented with a one-cycle done pulse.
- Lets the rest of the design request sin/cos of arbitrary angles without knowing the CORDIC convergence range.

---
 rtl/cordic_trig_frontend_if.sv | 31 +++
 rtl/cordic_trig_frontend.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cordic_trig_frontend_if.sv
// Request/response bundle for cordic_trig_frontend: the caller-facing request port plus
// the start/ready/done link to the CORDIC sine stage.
interface cordic_trig_frontend_if #(
  parameter int BIT_WIDTH = 16
);
  // Handshakes: a request transfers on a cycle where start=1 and ready=1 (func/angle sampled
  // then); done is a one-cycle pulse qualifying value/range_err. On the core side core_start
  // pulses once in a cycle with core_ready=1, and the first core_done pulse returns core_value.
  logic                        start;
  logic                        func;
  logic signed [BIT_WIDTH-1:0] angle;
  logic signed [BIT_WIDTH-1:0] value;
  logic                        ready;
  logic                        done;
  logic                        range_err;
  logic                        core_start;
  logic signed [BIT_WIDTH-1:0] core_angle;
  logic                        core_ready;
  logic                        core_done;
  logic signed [BIT_WIDTH-1:0] core_value;

  modport master (
    output start, func, angle, core_ready, core_done, core_value,
    input  value, ready, done, range_err, core_start, core_angle
  );

  modport slave (
    input  start, func, angle, core_ready, core_done, core_value,
    output value, ready, done, range_err, core_start, core_angle
  );
endinterface

// File: rtl/cordic_trig_frontend.sv
// Range reduction in front of the CORDIC sine stage: cos->sin offset, wrap to [-pi, pi],
// fold to [-pi/2, pi/2], then one start/done exchange with the core.
module cordic_trig_frontend #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 12,
  parameter int HALF_PI   = 6434,
  parameter int PI        = 12868,
  parameter int TWO_PI    = 25736
) (
  input  logic                  clk,
  input  logic                  reset,
  cordic_trig_frontend_if.slave bus,
  output logic [2:0]            dbg_state
);
  localparam int W1 = BIT_WIDTH + 1;
  localparam logic signed [W1-1:0] ZERO_X        = '0;
  localparam logic signed [W1-1:0] HALF_PI_X     = W1'(HALF_PI);
  localparam logic signed [W1-1:0] NEG_HALF_PI_X = -W1'(HALF_PI);
  localparam logic signed [W1-1:0] PI_X          = W1'(PI);
  localparam logic signed [W1-1:0] NEG_PI_X      = -W1'(PI);
  localparam logic signed [W1-1:0] TWO_PI_X      = W1'(TWO_PI);
  localparam logic signed [W1-1:0] NEG_TWO_PI_X  = -W1'(TWO_PI);
  localparam logic signed [W1-1:0] MAX_ANGLE_X   = W1'(TWO_PI - 1);
  // With at least 4 integer bits (sign included) the word can hold |x| > 2pi, so check it.
  localparam bit RANGE_CHECK = (BIT_WIDTH - FRAC_BITS) >= 4;

  typedef enum logic [2:0] {IDLE, WRAP, FOLD, ISSUE, WAIT, OUT} state_t;

  state_t state, next_state;
  logic   armed;
  logic   ready_c, done_c, core_start_c;
  logic   accept, in_range;

  logic signed [BIT_WIDTH-1:0] angle_q;
  logic                        func_q;
  logic signed [W1-1:0]        a_q;
  logic signed [BIT_WIDTH-1:0] core_angle_r;
  logic signed [BIT_WIDTH-1:0] value_r;
  logic                        range_err_r;

  logic signed [W1-1:0] angle_x, a_sum, a_wrap, r_fold;

  assign angle_x  = $signed({bus.angle[BIT_WIDTH-1], bus.angle});
  assign in_range = !RANGE_CHECK || ((angle_x >= NEG_TWO_PI_X) && (angle_x <= MAX_ANGLE_X));
  assign accept   = (state == IDLE) && armed && bus.start;

  always_comb begin
    a_sum  = $signed({angle_q[BIT_WIDTH-1], angle_q}) + (func_q ? HALF_PI_X : ZERO_X);
    a_wrap = a_sum;
    if (a_sum > PI_X)          a_wrap = a_sum - TWO_PI_X;
    else if (a_sum < NEG_PI_X) a_wrap = a_sum + TWO_PI_X;
    // sin(pi - a) = sin(a), so folding needs no sign fix-up on the result.
    r_fold = a_q;
    if (a_q > HALF_PI_X)          r_fold = PI_X - a_q;
    else if (a_q < NEG_HALF_PI_X) r_fold = NEG_PI_X - a_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
    end
  end

  always_comb begin
    next_state   = state;
    ready_c      = 1'b0;
    done_c       = 1'b0;
    core_start_c = 1'b0;
    case (state)
      IDLE: begin
        ready_c = armed;
        if (accept) next_state = in_range ? WRAP : OUT;
      end
      WRAP:  next_state = FOLD;
      FOLD:  next_state = ISSUE;
      ISSUE: begin
        if (bus.core_ready) begin
          core_start_c = 1'b1;
          next_state   = WAIT;
        end
      end
      WAIT:  if (bus.core_done) next_state = OUT;
      OUT: begin
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      angle_q      <= '0;
      func_q       <= 1'b0;
      a_q          <= '0;
      core_angle_r <= '0;
      value_r      <= '0;
      range_err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            angle_q <= bus.angle;
            func_q  <= bus.func;
            if (!in_range) begin
              value_r     <= '0;
              range_err_r <= 1'b1;
            end
          end
        end
        WRAP: a_q <= a_wrap;
        FOLD: core_angle_r <= BIT_WIDTH'(r_fold);
        WAIT: begin
          if (bus.core_done) begin
            value_r     <= bus.core_value;
            range_err_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready      = ready_c;
  assign bus.done       = done_c;
  assign bus.core_start = core_start_c;
  assign bus.core_angle = core_angle_r;
  assign bus.value      = value_r;
  assign bus.range_err  = range_err_r;
  assign dbg_state      = state;
endmodule
